// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-side arbiter and its read-side demux.
// The FIFO entry layout is {last, id, data}, with data in the least significant bits.
package fifo_arb_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, PKT = 1'b1} arb_state_t;

  localparam int unsigned FLD_DATA_LSB = 0;

  function automatic int unsigned fld_id_lsb(input int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned fld_last_bit(input int unsigned data_w, input int unsigned id_w);
    return data_w + id_w;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// ptr is expected to stay below N.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic found_s;
  int   idx_s;

  // Rotated first-set search.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 0; k < N; k++) begin
      idx_s = (int'(ptr) + k) % N;
      if (!found_s && req[idx_s]) begin
        found_s    = 1'b1;
        gnt[idx_s] = 1'b1;
        gnt_id     = ID_W'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin packet arbiter in front of a shared FIFO write port.
// Grant is held for a whole packet; each entry carries {last, source id, data}.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int ID_W   = $clog2(N_REQ),
  parameter int FIFO_W = DATA_W + ID_W + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      fifo_wen,
  output logic [FIFO_W-1:0]         fifo_wdata,
  input  logic                      fifo_afull,
  input  logic                      fifo_overflow,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy,
  output logic [31:0]               pkt_cnt,
  output logic                      ovf_err
);

  arb_state_t         state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]    gid_q, gid_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic               fifo_wen_q, fifo_wen_d;
  logic [FIFO_W-1:0]  fifo_wdata_q, fifo_wdata_d;
  logic [31:0]        pkt_cnt_q, pkt_cnt_d;
  logic               ovf_err_q, ovf_err_d;

  logic [N_REQ-1:0]   pick_gnt_s;
  logic [ID_W-1:0]    pick_id_s;
  logic               xfer_s;
  logic               sel_last_s;
  logic [DATA_W-1:0]  sel_data_s;

  rr_pick #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_rr_pick (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .gnt    (pick_gnt_s),
    .gnt_id (pick_id_s)
  );

  // Ready depends only on the held grant and back-pressure, never on valid.
  always_comb begin
    req_ready = '0;
    if (state_q == PKT && !fifo_afull) begin
      req_ready = grant_q;
    end else begin
      req_ready = '0;
    end
    xfer_s     = |(req_valid & req_ready);
    sel_last_s = req_last[gid_q];
    sel_data_s = req_data[int'(gid_q)*DATA_W +: DATA_W];
  end

  // Next-state logic for arbitration, output register and counters.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gid_d        = gid_q;
    rr_ptr_d     = rr_ptr_q;
    pkt_cnt_d    = pkt_cnt_q;
    fifo_wen_d   = xfer_s;
    fifo_wdata_d = fifo_wdata_q;
    ovf_err_d    = ovf_err_q | fifo_overflow;

    if (xfer_s) begin
      fifo_wdata_d = {sel_last_s, gid_q, sel_data_s};
    end else begin
      fifo_wdata_d = fifo_wdata_q;
    end

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = PKT;
          grant_d = pick_gnt_s;
          gid_d   = pick_id_s;
        end else begin
          state_d = IDLE;
        end
      end
      PKT: begin
        if (xfer_s && sel_last_s) begin
          state_d   = IDLE;
          grant_d   = '0;
          pkt_cnt_d = pkt_cnt_q + 32'd1;
          // Pointer moves just past the finished owner so it gets lowest priority next.
          if (gid_q == ID_W'(N_REQ - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = gid_q + 1'b1;
          end
        end else begin
          state_d = PKT;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      gid_q        <= '0;
      rr_ptr_q     <= '0;
      fifo_wen_q   <= 1'b0;
      fifo_wdata_q <= '0;
      pkt_cnt_q    <= 32'd0;
      ovf_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      gid_q        <= gid_d;
      rr_ptr_q     <= rr_ptr_d;
      fifo_wen_q   <= fifo_wen_d;
      fifo_wdata_q <= fifo_wdata_d;
      pkt_cnt_q    <= pkt_cnt_d;
      ovf_err_q    <= ovf_err_d;
    end
  end

  assign fifo_wen   = fifo_wen_q;
  assign fifo_wdata = fifo_wdata_q;
  assign grant      = grant_q;
  assign busy       = (state_q == PKT);
  assign pkt_cnt    = pkt_cnt_q;
  assign ovf_err    = ovf_err_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: a transaction-level owner/pointer model checked every
// cycle, plus literal expectations on the logged FIFO write stream.
module tb_fifo_wr_arb;

  localparam int N = 4;
  localparam int DW = 32;
  localparam int FW = 35;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_last = '0;
  logic [N-1:0]  req_ready;
  logic          fifo_wen;
  logic [FW-1:0] fifo_wdata;
  logic          fifo_afull = 1'b0;
  logic          fifo_overflow = 1'b0;
  logic [N-1:0]  grant;
  logic          busy;
  logic [31:0]   pkt_cnt;
  logic          ovf_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit abort = 1'b0;
  logic [FW-1:0] log_q[$];
  int            logc_q[$];

  fifo_wr_arb #(.N_REQ(N), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_wen(fifo_wen),
    .fifo_wdata(fifo_wdata), .fifo_afull(fifo_afull), .fifo_overflow(fifo_overflow),
    .grant(grant), .busy(busy), .pkt_cnt(pkt_cnt), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: owner index (-1 idle), round-robin start, expected registered outputs.
  int          m_owner;
  int          m_rr;
  logic        m_wen;
  logic [FW-1:0] m_wdata;
  logic [31:0] m_cnt;
  logic        m_ovf;

  function automatic int pick(input logic [N-1:0] v, input int rr);
    for (int k = 0; k < N; k++) if (v[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1; m_rr <= 0; m_wen <= 1'b0; m_wdata <= '0; m_cnt <= 32'd0; m_ovf <= 1'b0;
    end else begin
      m_ovf <= m_ovf | fifo_overflow;
      m_wen <= 1'b0;
      if (m_owner < 0) begin
        if (req_valid != '0) m_owner <= pick(req_valid, m_rr);
      end else if (req_valid[m_owner] && !fifo_afull) begin
        m_wen   <= 1'b1;
        m_wdata <= {req_last[m_owner], 2'(m_owner), req_data[m_owner*DW +: DW]};
        if (req_last[m_owner]) begin
          m_owner <= -1;
          m_rr    <= (m_owner + 1) % N;
          m_cnt   <= m_cnt + 32'd1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, and a log of every FIFO write.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [N-1:0] eg;
      eg = (m_owner >= 0) ? (4'd1 << m_owner) : 4'd0;
      chk("mdl_grant", grant, eg);
      chk("mdl_ready", req_ready, fifo_afull ? 4'd0 : eg);
      chk("mdl_busy", busy, m_owner >= 0);
      chk("mdl_wen", fifo_wen, m_wen);
      if (m_wen) chk("mdl_wdata", fifo_wdata, m_wdata);
      chk("mdl_pkt_cnt", pkt_cnt, m_cnt);
      chk("mdl_ovf_err", ovf_err, m_ovf);
      if (fifo_wen) begin
        log_q.push_back(fifo_wdata);
        logc_q.push_back(cyc);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Presents one packet on a source and advances a beat only after it is accepted.
  task automatic send_pkt(input int src, input int nb, input logic [31:0] base);
    for (int b = 0; b < nb; b++) begin
      bit acc = 1'b0;
      req_valid[src] = 1'b1;
      req_data[src*DW +: DW] = base + 32'(b);
      req_last[src] = (b == nb - 1);
      for (int t = 0; t < 200 && !acc && !abort; t++) begin
        @(negedge clk);
        acc = req_ready[src];
        @(posedge clk); #1;
      end
      if (!acc && !abort) chk("send_timeout", 64'(src), 64'hFFFF);
      if (!acc) break;
    end
    req_valid[src] = 1'b0;
    req_last[src] = 1'b0;
  endtask

  task automatic wait_log(input int n);
    for (int t = 0; t < 200 && log_q.size() < n; t++) @(negedge clk);
    if (log_q.size() < n) chk("wait_log_timeout", 64'(log_q.size()), 64'(n));
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    log_q.delete(); logc_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int t_v, n0;
    // Reset values.
    #12;
    chk("rst_ready", req_ready, 4'd0);
    chk("rst_wen", fifo_wen, 1'b0);
    chk("rst_wdata", fifo_wdata, 35'd0);
    chk("rst_grant", grant, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pkt_cnt", pkt_cnt, 32'd0);
    chk("rst_ovf", ovf_err, 1'b0);
    tick(1); rst_n = 1'b1; tick(1);

    // Source 2, three-beat packet.
    t_v = cyc;
    send_pkt(2, 3, 32'hA000_0000);
    tick(2);
    chk("t1_nwr", log_q.size(), 3);
    chk("t1_e0", log_q[0], {1'b0, 2'd2, 32'hA000_0000});
    chk("t1_e1", log_q[1], {1'b0, 2'd2, 32'hA000_0001});
    chk("t1_e2", log_q[2], {1'b1, 2'd2, 32'hA000_0002});
    chk("t1_latency", logc_q[0] - t_v, 2);
    chk("t1_pkt_cnt", pkt_cnt, 32'd1);

    // All four sources, two single-beat packets each.
    do_reset();
    fork
      begin send_pkt(0, 1, 32'h0000_0100); send_pkt(0, 1, 32'h0000_0101); end
      begin send_pkt(1, 1, 32'h0000_0110); send_pkt(1, 1, 32'h0000_0111); end
      begin send_pkt(2, 1, 32'h0000_0120); send_pkt(2, 1, 32'h0000_0121); end
      begin send_pkt(3, 1, 32'h0000_0130); send_pkt(3, 1, 32'h0000_0131); end
    join
    tick(2);
    chk("t2_nwr", log_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      logic [FW-1:0] e;
      e = {1'b1, 2'(i % 4), 32'h100 + 32'(16 * (i % 4)) + 32'(i / 4)};
      chk("t2_entry", log_q[i], e);
      if (i > 0) chk("t2_spacing", logc_q[i] - logc_q[i-1], 2);
    end
    chk("t2_pkt_cnt", pkt_cnt, 32'd8);

    // Source 0 asks while source 1 is mid-packet: no interleave.
    do_reset();
    fork
      send_pkt(1, 4, 32'h0000_0200);
      begin tick(2); send_pkt(0, 1, 32'h0000_0300); end
    join
    tick(2);
    chk("t3_nwr", log_q.size(), 5);
    for (int i = 0; i < 4; i++) chk("t3_src1", log_q[i], {(i == 3) ? 1'b1 : 1'b0, 2'd1, 32'h200 + 32'(i)});
    chk("t3_src0", log_q[4], {1'b1, 2'd0, 32'h0000_0300});

    // Almost-full back-pressure mid-packet.
    do_reset();
    fork
      send_pkt(2, 8, 32'h0000_0400);
      begin
        wait_log(3);
        @(posedge clk); #1 fifo_afull = 1'b1;
        n0 = log_q.size();
        #1 chk("t4_ready_drop", req_ready, 4'd0);
        tick(5);
        chk("t4_trailing", (log_q.size() - n0) <= 1, 1'b1);
        fifo_afull = 1'b0;
      end
    join
    tick(2);
    chk("t4_nwr", log_q.size(), 8);
    for (int i = 0; i < 8; i++) chk("t4_entry", log_q[i], {(i == 7) ? 1'b1 : 1'b0, 2'd2, 32'h400 + 32'(i)});

    // Overflow is sticky until reset.
    fifo_overflow = 1'b1; tick(1); fifo_overflow = 1'b0;
    tick(1); chk("t5_ovf_set", ovf_err, 1'b1);
    tick(5); chk("t5_ovf_hold", ovf_err, 1'b1);
    do_reset();
    chk("t5_ovf_clr", ovf_err, 1'b0);

    // Asynchronous reset mid-packet, then arbitration restarts from source 0.
    send_pkt(1, 1, 32'h0000_0500);
    tick(1);
    fork
      send_pkt(3, 6, 32'h0000_0600);
      begin
        wait_log(3);
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        chk("t6_ready", req_ready, 4'd0);
        chk("t6_wen", fifo_wen, 1'b0);
        chk("t6_wdata", fifo_wdata, 35'd0);
        chk("t6_grant", grant, 4'd0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_pkt_cnt", pkt_cnt, 32'd0);
        chk("t6_ovf", ovf_err, 1'b0);
        abort = 1'b1;
      end
    join
    abort = 1'b0;
    tick(1); rst_n = 1'b1; tick(1);
    log_q.delete(); logc_q.delete();
    fork
      send_pkt(3, 1, 32'h0000_0700);
      send_pkt(0, 1, 32'h0000_0800);
    join
    tick(2);
    chk("t6_nwr", log_q.size(), 2);
    chk("t6_first", log_q[0], {1'b1, 2'd0, 32'h0000_0800});
    chk("t6_second", log_q[1], {1'b1, 2'd3, 32'h0000_0700});

    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
